// File: rtl/s_to_p_pkg.sv
// Shared types and helpers for the s_to_p_frame serial-to-parallel framer.
package s_to_p_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // MSB mask for offset-binary to two's-complement conversion (samples up to 32 bits).
  function automatic logic [31:0] msb_mask(input int unsigned width, input bit flip);
    return flip ? (32'd1 << (width - 1)) : '0;
  endfunction

endpackage

// File: rtl/s_to_p_window.sv
// DEPTH-entry shift-register window; entry 0 is oldest, entry DEPTH-1 newest.
module s_to_p_window #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [DEPTH*WIDTH-1:0]   win_o,
  output logic [DEPTH*WIDTH-1:0]   win_next_o
);

  logic [DEPTH*WIDTH-1:0] win_q, win_d;

  always_comb begin
    win_d = win_q;
    if (shift_i) win_d = {din_i, win_q[DEPTH*WIDTH-1:WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (reset) win_q <= '0;
    else       win_q <= win_d;
  end

  assign win_o      = win_q;
  assign win_next_o = win_d;

endmodule

// File: rtl/s_to_p_frame.sv
// Sliding-window framer: publishes a DEPTH-sample snapshot every HOP accepts.
// Optional input decimation is enabled with `define S_TO_P_FRAME_DECIM_EN.
module s_to_p_frame
  import s_to_p_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned HOP       = 64,
  parameter int unsigned SIGN_FLIP = 1,
  parameter int unsigned DECIM     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       X,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [DEPTH*WIDTH-1:0] Y,
  output logic                   overrun,
  input  logic                   clr_ovr,
  output logic                   primed
);

  localparam int unsigned FW = clog2(DEPTH + 1);
  localparam int unsigned HW = (HOP > 1) ? clog2(HOP) : 1;
  localparam logic [WIDTH-1:0] FLIP_MASK = WIDTH'(msb_mask(WIDTH, SIGN_FLIP != 0));

  logic accept;

`ifdef S_TO_P_FRAME_DECIM_EN
  localparam int unsigned DW = (DECIM > 1) ? clog2(DECIM) : 1;
  logic [DW-1:0] dec_q, dec_d;

  always_comb begin
    dec_d = dec_q;
    if (in_valid) dec_d = (dec_q == DW'(DECIM - 1)) ? '0 : dec_q + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) dec_q <= '0;
    else       dec_q <= dec_d;
  end

  assign accept = in_valid && (dec_q == '0);
`else
  logic unused_decim;
  assign unused_decim = (DECIM != 0);
  assign accept       = in_valid;
`endif

  logic [WIDTH-1:0]       sample;
  logic [DEPTH*WIDTH-1:0] win_next;
  logic [DEPTH*WIDTH-1:0] unused_win;

  assign sample = X ^ FLIP_MASK;

  s_to_p_window #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_window (
    .clk       (clk),
    .reset     (reset),
    .shift_i   (accept),
    .din_i     (sample),
    .win_o     (unused_win),
    .win_next_o(win_next)
  );

  state_e                 state_q, state_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic [HW-1:0]          hop_q, hop_d;
  logic                   primed_q, primed_d;
  logic                   fv_q, fv_d;
  logic                   ovr_q, ovr_d;
  logic [DEPTH*WIDTH-1:0] y_q, y_d;
  logic                   frame_due;
  logic                   drop;

  // Frame scheduling: first frame on the DEPTH-th accept, then every HOP accepts.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    hop_d     = hop_q;
    primed_d  = primed_q;
    frame_due = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          fill_d = fill_q + FW'(1);
          if (fill_q == FW'(DEPTH - 1)) begin
            frame_due = 1'b1;
            state_d   = RUN;
            primed_d  = 1'b1;
            hop_d     = '0;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (hop_q == HW'(HOP - 1)) begin
            frame_due = 1'b1;
            hop_d     = '0;
          end else begin
            hop_d = hop_q + HW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // A due frame loads if the slot is empty or being drained this cycle; otherwise it is dropped.
  always_comb begin
    fv_d  = fv_q;
    y_d   = y_q;
    drop  = 1'b0;
    if (frame_due) begin
      if (!fv_q || frame_ready) begin
        y_d  = win_next;
        fv_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (fv_q && frame_ready) begin
      fv_d = 1'b0;
    end
    ovr_d = drop ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL;
      fill_q   <= '0;
      hop_q    <= '0;
      primed_q <= 1'b0;
      fv_q     <= 1'b0;
      ovr_q    <= 1'b0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      hop_q    <= hop_d;
      primed_q <= primed_d;
      fv_q     <= fv_d;
      ovr_q    <= ovr_d;
      y_q      <= y_d;
    end
  end

  assign frame_valid = fv_q;
  assign Y           = y_q;
  assign overrun     = ovr_q;
  assign primed      = primed_q;

endmodule

// File: tb/tb_s_to_p_frame.sv
// Directed table-driven bench for s_to_p_frame (WIDTH=10, DEPTH=4, HOP=2).
module tb_s_to_p_frame;

  localparam int unsigned W = 10;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] X = '0;
  logic         frame_ready = 1'b0;
  logic         clr_ovr = 1'b0;
  logic         frame_valid, overrun, primed;
  logic [D*W-1:0] Y;

  logic         in_valid2 = 1'b0;
  logic [W-1:0] X2 = '0;
  logic         frame_valid2, overrun2, primed2;
  logic [D*W-1:0] Y2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  s_to_p_frame #(
    .WIDTH(W), .DEPTH(D), .HOP(2), .SIGN_FLIP(1), .DECIM(2)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .X(X),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .Y(Y),
    .overrun(overrun), .clr_ovr(clr_ovr), .primed(primed)
  );

  s_to_p_frame #(
    .WIDTH(W), .DEPTH(D), .HOP(2), .SIGN_FLIP(0), .DECIM(2)
  ) dut_nf (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .X(X2),
    .frame_valid(frame_valid2), .frame_ready(1'b1), .Y(Y2),
    .overrun(overrun2), .clr_ovr(1'b0), .primed(primed2)
  );

  typedef struct {
    logic         vld;
    logic [W-1:0] x;
    logic         rdy;
    logic         clr;
    logic         fv;
    logic [D*W-1:0] y;
    logic         ovr;
    logic         prm;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [D*W-1:0] pk(input logic [W-1:0] e0, input logic [W-1:0] e1,
                                         input logic [W-1:0] e2, input logic [W-1:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step(input logic vld, input logic [W-1:0] x, input logic rdy, input logic clr);
    in_valid    = vld;
    X           = x;
    frame_ready = rdy;
    clr_ovr     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 10'h200, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 10'h201, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 10'h202, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 10'h203, 1'b1, 1'b0, 1'b1, pk(10'h000, 10'h001, 10'h002, 10'h003), 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 10'h204, 1'b1, 1'b0, 1'b0, pk(10'h000, 10'h001, 10'h002, 10'h003), 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 10'h205, 1'b1, 1'b0, 1'b1, pk(10'h002, 10'h003, 10'h004, 10'h005), 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 10'h206, 1'b0, 1'b0, 1'b1, pk(10'h002, 10'h003, 10'h004, 10'h005), 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 10'h207, 1'b0, 1'b0, 1'b1, pk(10'h002, 10'h003, 10'h004, 10'h005), 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, pk(10'h002, 10'h003, 10'h004, 10'h005), 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 10'h208, 1'b0, 1'b0, 1'b1, pk(10'h002, 10'h003, 10'h004, 10'h005), 1'b1, 1'b1};
    vecs[10] = '{1'b1, 10'h209, 1'b0, 1'b0, 1'b1, pk(10'h002, 10'h003, 10'h004, 10'h005), 1'b1, 1'b1};
    vecs[11] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b1, pk(10'h002, 10'h003, 10'h004, 10'h005), 1'b0, 1'b1};
    vecs[12] = '{1'b1, 10'h20A, 1'b0, 1'b0, 1'b1, pk(10'h002, 10'h003, 10'h004, 10'h005), 1'b0, 1'b1};
    vecs[13] = '{1'b1, 10'h20B, 1'b1, 1'b0, 1'b1, pk(10'h008, 10'h009, 10'h00A, 10'h00B), 1'b0, 1'b1};
    vecs[14] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, pk(10'h008, 10'h009, 10'h00A, 10'h00B), 1'b0, 1'b1};
    vecs[15] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, pk(10'h008, 10'h009, 10'h00A, 10'h00B), 1'b0, 1'b1};
    vecs[16] = '{1'b1, 10'h20C, 1'b0, 1'b0, 1'b0, pk(10'h008, 10'h009, 10'h00A, 10'h00B), 1'b0, 1'b1};
    vecs[17] = '{1'b1, 10'h20D, 1'b0, 1'b0, 1'b1, pk(10'h00A, 10'h00B, 10'h00C, 10'h00D), 1'b0, 1'b1};
    vecs[18] = '{1'b1, 10'h20E, 1'b0, 1'b0, 1'b1, pk(10'h00A, 10'h00B, 10'h00C, 10'h00D), 1'b0, 1'b1};
    vecs[19] = '{1'b1, 10'h20F, 1'b0, 1'b1, 1'b1, pk(10'h00A, 10'h00B, 10'h00C, 10'h00D), 1'b1, 1'b1};

    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("reset_fv", 64'(frame_valid), 64'd0);
    check("reset_y", 64'(Y), 64'd0);
    check("reset_primed", 64'(primed), 64'd0);
    check("reset_ovr", 64'(overrun), 64'd0);

`ifdef S_TO_P_FRAME_DECIM_EN
    for (int i = 0; i < 8; i++) begin
      step(1'b1, W'(10'h200 + i), 1'b0, 1'b0);
      if (i == 5) check("decim_fv_early", 64'(frame_valid), 64'd0);
    end
    check("decim_fv", 64'(frame_valid), 64'd1);
    check("decim_y", 64'(Y), 64'(pk(10'h000, 10'h002, 10'h004, 10'h006)));
    check("decim_primed", 64'(primed), 64'd1);
`else
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].vld, vecs[i].x, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d_fv", i), 64'(frame_valid), 64'(vecs[i].fv));
      check($sformatf("vec%0d_y", i), 64'(Y), 64'(vecs[i].y));
      check($sformatf("vec%0d_ovr", i), 64'(overrun), 64'(vecs[i].ovr));
      check($sformatf("vec%0d_primed", i), 64'(primed), 64'(vecs[i].prm));
    end

    // Reset discards the pending frame and sticky overrun.
    do_reset();
    check("rst2_fv", 64'(frame_valid), 64'd0);
    check("rst2_ovr", 64'(overrun), 64'd0);
    check("rst2_primed", 64'(primed), 64'd0);
    check("rst2_y", 64'(Y), 64'd0);

    // Reset mid-FILL after three accepts.
    for (int i = 0; i < 3; i++) step(1'b1, W'(10'h210 + i), 1'b1, 1'b0);
    check("midfill_fv", 64'(frame_valid), 64'd0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, W'(10'h220 + i), 1'b1, 1'b0);
      check($sformatf("refill%0d_fv", i), 64'(frame_valid), 64'd0);
    end
    step(1'b1, 10'h223, 1'b1, 1'b0);
    check("refill_fv", 64'(frame_valid), 64'd1);
    check("refill_y", 64'(Y), 64'(pk(10'h020, 10'h021, 10'h022, 10'h023)));
    check("refill_primed", 64'(primed), 64'd1);
    step(1'b0, '0, 1'b0, 1'b0);

    // SIGN_FLIP = 0 instance stores samples unchanged.
    in_valid2 = 1'b1; X2 = 10'h3FF; @(posedge clk); #1;
    X2 = 10'h000; @(posedge clk); #1;
    X2 = 10'h155; @(posedge clk); #1;
    check("noflip_fv_early", 64'(frame_valid2), 64'd0);
    X2 = 10'h2AA; @(posedge clk); #1;
    in_valid2 = 1'b0;
    check("noflip_fv", 64'(frame_valid2), 64'd1);
    check("noflip_y", 64'(Y2), 64'(pk(10'h3FF, 10'h000, 10'h155, 10'h2AA)));
    check("noflip_primed", 64'(primed2), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
